// File: rtl/v68k_bus_pkg.sv
// Shared types for the 68k-style asynchronous bus responder: FSM state encoding and bus word.
package v68k_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } bus_state_e;

  typedef logic [15:0] word_t;

endpackage

// File: rtl/bus_responder_if.sv
// 68k-style slave bus: word address, strobes, direction, data, and DTACK/BERR termination.
interface bus_responder_if;
  import v68k_bus_pkg::*;

  logic [31:1] A;
  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  word_t       D_IN;
  word_t       D_OUT;
  logic        D_OE;
  logic        DTACK;
  logic        BERR;

  modport master (
    output A, AS, UDS, LDS, RW, D_IN,
    input  D_OUT, D_OE, DTACK, BERR
  );

  modport slave (
    input  A, AS, UDS, LDS, RW, D_IN,
    output D_OUT, D_OE, DTACK, BERR
  );

endinterface

// File: rtl/bus_responder_ram.sv
// Single-port word array with per-byte-lane write enables and registered read data.
module bus_responder_ram
  import v68k_bus_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          CLK,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    we,
  input  logic          rd_en,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [WORDS];
  word_t rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem[addr];
  end

  // Contents are deliberately not reset; they survive a RESET of the responder.
  always_ff @(posedge CLK) begin
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-backed 68k-style bus responder with programmable wait states.
// Define BUS_RESPONDER_BERR_EN to terminate out-of-window accesses with BERR instead of DTACK.
//
// state   | meaning
// IDLE    | waiting for AS with at least one data strobe
// WAIT    | counting down wait states; AS low aborts
// ACK     | DTACK (and read data) held until AS drops
// DONE    | BERR held until AS drops
module bus_responder
  import v68k_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 2
) (
  input logic           CLK,
  input logic           RESET,
  bus_responder_if.slave bus
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(2 * MEM_WORDS);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);
`ifdef BUS_RESPONDER_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif

  bus_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:1] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  lanes_q, lanes_d;
  word_t       wdata_q, wdata_d;
  logic        dtack_q, dtack_d;
  logic        berr_q, berr_d;
  logic        oe_q, oe_d;

  logic [32:0]   offset;
  logic          hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    ram_we;
  logic          ram_rd;
  word_t         ram_rdata;

  // 33-bit subtraction: a borrow into bit 32 means the address is below the window.
  assign offset  = {1'b0, addr_q, 1'b0} - {1'b0, BASE_ADDR};
  assign hit     = !offset[32] && (offset < WIN_BYTES);
  assign ram_idx = offset[AW:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    lanes_d = lanes_q;
    wdata_d = wdata_q;
    dtack_d = dtack_q;
    berr_d  = berr_q;
    oe_d    = oe_q;
    ram_we  = 2'b00;
    ram_rd  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.AS && (bus.UDS || bus.LDS)) begin
          addr_d  = bus.A;
          rw_d    = bus.RW;
          lanes_d = {bus.UDS, bus.LDS};
          wdata_d = bus.D_IN;
          cnt_d   = WS;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.AS) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          if (!hit && BERR_EN) begin
            berr_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            dtack_d = 1'b1;
            oe_d    = rw_q;
            state_d = ST_ACK;
            if (hit) begin
              ram_rd = rw_q;
              ram_we = rw_q ? 2'b00 : lanes_q;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (!bus.AS) begin
          dtack_d = 1'b0;
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!bus.AS) begin
          berr_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset landing on the completion edge must not disturb the array.
    if (RESET) begin
      ram_we = 2'b00;
      ram_rd = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      lanes_q <= 2'b00;
      wdata_q <= '0;
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      lanes_q <= lanes_d;
      wdata_q <= wdata_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
      oe_q    <= oe_d;
    end
  end

  bus_responder_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .CLK   (CLK),
    .addr  (ram_idx),
    .we    (ram_we),
    .rd_en (ram_rd),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.DTACK = dtack_q;
  assign bus.BERR  = berr_q;
  assign bus.D_OE  = oe_q;
  assign bus.D_OUT = (oe_q && hit) ? ram_rdata : 16'h0000;

endmodule
